sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word-address width of the shared main-RAM port.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum RWAIT cycles before a forced read completion.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m_read, m_write  input  3 each  per-requester strobes; bit 0 icache, bit 1 dcache, bit 2 debugger.
REQ-006 SHALL have port m_addr  input  3*ADDR_W  packed addresses; requester i in slice i.
REQ-007 SHALL have ports m_wdata  input  96  and  m_be  input  12  packed write data and byte enables, 32/4 bits per requester.
REQ-008 SHALL have port m_waitrequest  output  3  per-requester stall.
REQ-009 SHALL have ports m_rdata  output  32  and  m_rvalid  output  3  shared read data and per-requester read-valid.
REQ-010 SHALL have ports s_addr  output  ADDR_W,  s_read  output  1,  s_write  output  1,  s_wdata  output  32,  s_be  output  4  toward the SDRAM controller.
REQ-011 SHALL have ports s_waitrequest  input  1,  s_rdata  input  32,  s_rvalid  input  1  from the SDRAM controller.
REQ-012 SHALL have ports grant_id  output  2  current owner,  busy  output  1  state != IDLE,  timeout_err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RWAIT, with one outstanding transaction at most.
REQ-014 SHALL treat requester i as requesting when m_read[i] | m_write[i]; when both are set, write wins.
REQ-015 SHALL, in IDLE with any request, select the first requesting index at or after rr_ptr (mod 3), latch its addr/wdata/be/op and grant_id, and enter ISSUE next cycle.
REQ-016 SHALL drive s_addr/s_wdata/s_be/s_read/s_write only from latched registers; s_read=s_write=0 outside ISSUE.
REQ-017 SHALL hold ISSUE while s_waitrequest=1; latched values stay stable.
REQ-018 SHALL, in ISSUE with s_waitrequest=0, drive m_waitrequest[grant_id]=0 combinationally that cycle; write -> IDLE, read -> RWAIT.
REQ-019 SHALL drive m_waitrequest[i]=1 for every other requester and cycle, including IDLE.
REQ-020 SHALL, in RWAIT on s_rvalid=1, assert m_rvalid[grant_id]=1 and m_rdata=s_rdata combinationally for one cycle, then go to IDLE.
REQ-021 SHALL, in RWAIT, count cycles from 0; when the count reaches TIMEOUT without s_rvalid, assert m_rvalid[grant_id] with m_rdata=32'hFFFFFFFF, set timeout_err, and go to IDLE.
REQ-022 SHALL ignore s_rvalid received outside RWAIT; m_rvalid stays 0.
REQ-023 SHALL set rr_ptr to (grant_id+1) mod 3 on each completion (write accept, read data, or timeout).
REQ-024 SHALL ignore requester strobe changes after latching; a granted transaction always completes.
REQ-025 SHALL keep m_rdata=0 whenever m_rvalid=0.
REQ-026 SHALL keep idle-to-issue latency at 1 cycle, with a minimum of 2 cycles per write and 3 cycles per read, back-to-back.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, rr_ptr=0, grant_id=0, timeout count=0, timeout_err=0, and all latches=0.
REQ-028 SHALL hold outputs in reset at s_read=s_write=0, m_waitrequest=3'b111, m_rvalid=0, m_rdata=0, busy=0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation, with no m_rvalid issued for it.

Verification
REQ-030 SHALL pass: dcache write addr 0x100 data 0xA5A5A5A5 be 0xF, s_waitrequest low -> s_write for 1 cycle with those values, m_waitrequest[1]=0 that cycle, busy back to 0 after 2 cycles.
REQ-031 SHALL pass: all three read simultaneously and continuously, s_rvalid 2 cycles after accept -> grants in order 0,1,2,0, each m_rvalid on the correct bit only.
REQ-032 SHALL pass: icache read with s_waitrequest held 5 cycles -> s_addr stable across all 5, exactly one accept, m_rvalid[0] with s_rdata=0x12345678.
REQ-033 SHALL pass: debugger read, SDRAM never returns s_rvalid -> m_rvalid[2] at TIMEOUT cycles with data 0xFFFFFFFF, timeout_err=1 until reset, and a later stray s_rvalid ignored.
REQ-034 SHALL pass: rst_n pulsed low in RWAIT -> outputs at reset values immediately, rr_ptr=0, no m_rvalid issued.
REQ-035 SHALL pass: requester with m_read and m_write both set -> s_write issued, s_read not.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM port among icache, dcache and debugger
module sdram_port_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          m_read,
  input  logic [2:0]          m_write,
  input  logic [3*ADDR_W-1:0] m_addr,
  input  logic [95:0]         m_wdata,
  input  logic [11:0]         m_be,
  output logic [2:0]          m_waitrequest,
  output logic [31:0]         m_rdata,
  output logic [2:0]          m_rvalid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_read,
  output logic                s_write,
  output logic [31:0]         s_wdata,
  output logic [3:0]          s_be,
  input  logic                s_waitrequest,
  input  logic [31:0]         s_rdata,
  input  logic                s_rvalid,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t             state;
  logic [1:0]         rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  lat_addr;
  logic [31:0]        lat_wdata;
  logic [3:0]         lat_be;

  logic [2:0]         req;
  logic [2:0]         cand;
  logic [1:0]         sel;
  logic               found;
  logic [1:0]         next_ptr;
  logic               accept;
  logic               timeout_hit;
  logic               rdone;

  assign req = m_read | m_write;

  // First requester at or after rr_ptr, wrapping modulo 3.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        sel   = cand[1:0];
      end
    end
  end

  assign next_ptr    = (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
  assign accept      = (state == ISSUE) && !s_waitrequest;
  assign timeout_hit = (state == RWAIT) && !s_rvalid && (cnt == CNT_W'(TIMEOUT));
  assign rdone       = (state == RWAIT) && (s_rvalid || timeout_hit);

  assign s_addr  = lat_addr;
  assign s_wdata = lat_wdata;
  assign s_be    = lat_be;
  assign busy    = (state != IDLE);

  always_comb begin
    m_waitrequest = 3'b111;
    m_rvalid      = 3'b000;
    m_rdata       = 32'd0;
    if (accept) m_waitrequest[grant_id] = 1'b0;
    if (rdone) begin
      m_rvalid[grant_id] = 1'b1;
      m_rdata            = s_rvalid ? s_rdata : 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      grant_id    <= 2'd0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= 32'd0;
      lat_be      <= 4'd0;
      s_read      <= 1'b0;
      s_write     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= sel;
            lat_addr  <= m_addr[int'(sel)*ADDR_W +: ADDR_W];
            lat_wdata <= m_wdata[int'(sel)*32 +: 32];
            lat_be    <= m_be[int'(sel)*4 +: 4];
            s_write   <= m_write[sel];
            s_read    <= !m_write[sel];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!s_waitrequest) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            cnt     <= '0;
            if (s_write) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state  <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (rdone) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
            if (timeout_hit) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          m_read, m_write;
  logic [3*ADDR_W-1:0] m_addr;
  logic [95:0]         m_wdata;
  logic [11:0]         m_be;
  logic [2:0]          m_waitrequest;
  logic [31:0]         m_rdata;
  logic [2:0]          m_rvalid;
  logic [ADDR_W-1:0]   s_addr;
  logic                s_read, s_write;
  logic [31:0]         s_wdata;
  logic [3:0]          s_be;
  logic                s_waitrequest;
  logic [31:0]         s_rdata;
  logic                s_rvalid;
  logic [1:0]          grant_id;
  logic                busy, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_waitrequest(m_waitrequest), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .s_addr(s_addr), .s_read(s_read), .s_write(s_write), .s_wdata(s_wdata), .s_be(s_be),
    .s_waitrequest(s_waitrequest), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; m_read = 3'b0; m_write = 3'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_waitrequest = 1'b0; s_rdata = 32'd0; s_rvalid = 1'b0;

    // reset values
    @(negedge clk); #1;
    check("rst_s_read", 32'(s_read), 0);
    check("rst_s_write", 32'(s_write), 0);
    check("rst_m_wait", 32'(m_waitrequest), 32'h7);
    check("rst_m_rvalid", 32'(m_rvalid), 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tmo", 32'(timeout_err), 0);

    // dcache write
    @(negedge clk);
    rst_n = 1'b1; m_write = 3'b010;
    m_addr[ADDR_W +: ADDR_W] = 25'h100; m_wdata[63:32] = 32'hA5A5A5A5; m_be[7:4] = 4'hF;
    #1;
    check("wr_idle_busy", 32'(busy), 0);
    check("wr_idle_wait", 32'(m_waitrequest), 32'h7);
    @(negedge clk); m_write = 3'b000; #1;
    check("wr_s_write", 32'(s_write), 1);
    check("wr_s_read", 32'(s_read), 0);
    check("wr_s_addr", 32'(s_addr), 32'h100);
    check("wr_s_wdata", s_wdata, 32'hA5A5A5A5);
    check("wr_s_be", 32'(s_be), 32'hF);
    check("wr_m_wait", 32'(m_waitrequest), 32'h5);
    check("wr_grant", 32'(grant_id), 1);
    @(negedge clk); #1;
    check("wr_done_busy", 32'(busy), 0);
    check("wr_done_s_write", 32'(s_write), 0);
    check("wr_done_wait", 32'(m_waitrequest), 32'h7);

    // fresh reset, then all three read continuously: grants 0,1,2,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_read = 3'b111;
    m_addr = {25'h12, 25'h11, 25'h10};
    for (int k = 0; k < 4; k++) begin
      int e;
      e = k % 3;
      #1 check("rr_idle_busy", 32'(busy), 0);
      @(negedge clk); #1;
      check("rr_s_read", 32'(s_read), 1);
      check("rr_grant", 32'(grant_id), 32'(e));
      check("rr_wait", 32'(m_waitrequest), 32'(~(3'b001 << e) & 3'b111));
      check("rr_addr", 32'(s_addr), 32'h10 + 32'(e));
      @(negedge clk); #1;
      check("rr_no_rvalid", 32'(m_rvalid), 0);
      @(negedge clk); s_rvalid = 1'b1; s_rdata = 32'hD00 + 32'(k); #1;
      check("rr_rvalid", 32'(m_rvalid), 32'(3'b001 << e));
      check("rr_rdata", m_rdata, 32'hD00 + 32'(k));
      @(negedge clk); s_rvalid = 1'b0;
    end
    m_read = 3'b000;

    // icache read held off by s_waitrequest for 5 cycles
    m_read = 3'b001; s_waitrequest = 1'b1; m_addr[ADDR_W-1:0] = 25'h1ABCD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); m_read = 3'b000; #1;
      check("hold_s_read", 32'(s_read), 1);
      check("hold_addr", 32'(s_addr), 32'h1ABCD);
      check("hold_wait", 32'(m_waitrequest), 32'h7);
    end
    @(negedge clk); s_waitrequest = 1'b0; #1;
    check("hold_accept", 32'(m_waitrequest), 32'h6);
    check("hold_grant", 32'(grant_id), 0);
    @(negedge clk); s_rvalid = 1'b1; s_rdata = 32'h12345678; #1;
    check("hold_rvalid", 32'(m_rvalid), 32'h1);
    check("hold_rdata", m_rdata, 32'h12345678);
    @(negedge clk); s_rvalid = 1'b0; #1;
    check("hold_after_rvalid", 32'(m_rvalid), 0);
    check("hold_after_busy", 32'(busy), 0);
    check("hold_after_wait", 32'(m_waitrequest), 32'h7);

    // debugger read that never returns
    m_read = 3'b100; m_addr[2*ADDR_W +: ADDR_W] = 25'h300;
    @(negedge clk); m_read = 3'b000; #1;
    check("tmo_s_read", 32'(s_read), 1);
    check("tmo_grant", 32'(grant_id), 2);
    check("tmo_accept", 32'(m_waitrequest), 32'h3);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk); #1;
      check("tmo_early_rvalid", 32'(m_rvalid), 0);
    end
    @(negedge clk); #1;
    check("tmo_rvalid", 32'(m_rvalid), 32'h4);
    check("tmo_rdata", m_rdata, 32'hFFFFFFFF);
    @(negedge clk); s_rvalid = 1'b1; s_rdata = 32'h0000DEAD; #1;
    check("tmo_flag", 32'(timeout_err), 1);
    check("tmo_idle_busy", 32'(busy), 0);
    check("stray_rvalid", 32'(m_rvalid), 0);
    check("stray_rdata", m_rdata, 0);
    @(negedge clk); s_rvalid = 1'b0;

    // read and write both set: write wins
    m_read = 3'b010; m_write = 3'b010;
    m_addr[ADDR_W +: ADDR_W] = 25'h155; m_wdata[63:32] = 32'h600DF00D; m_be[7:4] = 4'h3;
    @(negedge clk); m_read = 3'b000; m_write = 3'b000; #1;
    check("rw_s_write", 32'(s_write), 1);
    check("rw_s_read", 32'(s_read), 0);
    check("rw_wdata", s_wdata, 32'h600DF00D);
    check("rw_be", 32'(s_be), 32'h3);
    check("rw_wait", 32'(m_waitrequest), 32'h5);
    @(negedge clk); #1;
    check("rw_busy", 32'(busy), 0);
    check("tmo_sticky", 32'(timeout_err), 1);

    // reset pulse while in RWAIT
    m_read = 3'b001;
    @(negedge clk); m_read = 3'b000; #1;
    check("rst_mid_s_read", 32'(s_read), 1);
    check("rst_mid_grant", 32'(grant_id), 0);
    @(negedge clk); #1;
    check("rst_mid_rwait_busy", 32'(busy), 1);
    rst_n = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77; #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rvalid", 32'(m_rvalid), 0);
    check("rst_mid_rdata", m_rdata, 0);
    check("rst_mid_wait", 32'(m_waitrequest), 32'h7);
    check("rst_mid_tmo", 32'(timeout_err), 0);
    check("rst_mid_s_read0", 32'(s_read), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_after_rvalid", 32'(m_rvalid), 0);
    s_rvalid = 1'b0; m_read = 3'b110;
    @(negedge clk); m_read = 3'b000; #1;
    check("rst_ptr_grant", 32'(grant_id), 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
